// File: rtl/gin_multicast_if.sv
// ----------------------------------------------------------------------------
// gin_multicast_if
//   Source-side handshake bus of the global input network. The ifmap
//   controller (master) presents one tagged value per transaction. The
//   network (slave) returns ready when every targeted PE can take it.
//
//   enable   master->slave  transaction valid
//   ready    slave->master  transaction accepted this cycle
//   row_tag  master->slave  target row ID
//   col_tag  master->slave  target column ID
//   value    master->slave  data word to multicast
// ----------------------------------------------------------------------------
interface gin_multicast_if #(
  parameter int ROW_LEN   = 4,
  parameter int ID_LEN    = 5,
  parameter int VALUE_LEN = 8
);
  logic                 enable;
  logic                 ready;
  logic [ROW_LEN-1:0]   row_tag;
  logic [ID_LEN-1:0]    col_tag;
  logic [VALUE_LEN-1:0] value;

  modport master (output enable, row_tag, col_tag, value, input  ready);
  modport slave  (input  enable, row_tag, col_tag, value, output ready);
endinterface

// File: rtl/gin_multicast.sv
// ----------------------------------------------------------------------------
// gin_multicast
//   Global input network for the PE array. Each transaction carries a
//   (row_tag, col_tag) pair. The value is multicast to every PE whose bus
//   row ID equals row_tag and whose own ID equals col_tag. The transfer is
//   all-or-nothing: ready is held low until every hit PE is ready together.
//   With no hit PE, the transaction is consumed and dropped.
//
//   Row IDs (one per X-bus) and PE IDs (one per PE) are loaded through two
//   independent scan chains. All-ones is the reserved "unconfigured" ID.
//   It never matches, not even an all-ones tag. Reset loads it everywhere.
//
//   clk, rst          clock / async active-high reset
//   src               source handshake bus (slave side)
//   i_set_id          shift the PE ID chain one step
//   i_id_scan_in      ID chain serial input (enters PE 0)
//   o_id_scan_out     ID chain tail (last PE's ID)
//   i_set_row         shift the row ID chain one step
//   i_row_scan_in     row chain serial input (enters bus 0)
//   o_row_scan_out    row chain tail (last bus's row ID)
//   i_pe_ready        per-PE ready, PE k = bus*PE_NUMS + pe is bit k
//   o_pe_enable_data  per-PE {enable, data}, VALUE_LEN+1 bits per PE
// ----------------------------------------------------------------------------

// Per-PE slice: own ID register (one link of the ID scan chain) plus the
// column match, enable gating and the ready-blocking term.
module gin_multicast_pe #(
  parameter int ID_LEN    = 5,
  parameter int VALUE_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_shift,
  input  logic [ID_LEN-1:0]    i_id_in,
  output logic [ID_LEN-1:0]    o_id,
  input  logic                 i_bus_hit,
  input  logic [ID_LEN-1:0]    i_col_tag,
  input  logic                 i_enable,
  input  logic [VALUE_LEN-1:0] i_value,
  input  logic                 i_pe_ready,
  output logic [VALUE_LEN:0]   o_en_data,
  output logic                 o_blocked
);
  localparam logic [ID_LEN-1:0] ID_UNCFG = '1;

  logic [ID_LEN-1:0] r_id;
  logic              w_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_id <= ID_UNCFG;
    else if (i_shift) r_id <= i_id_in;
  end

  assign o_id      = r_id;
  assign w_hit     = i_bus_hit && (r_id == i_col_tag) && (r_id != ID_UNCFG);
  // Data is broadcast to every PE; only the enable bit is targeted.
  assign o_en_data = {i_enable & w_hit, i_value};
  // A hit PE that cannot take the value stalls the whole multicast.
  assign o_blocked = w_hit & ~i_pe_ready;
endmodule

module gin_multicast #(
  parameter int XBUS_NUMS = 12,
  parameter int PE_NUMS   = 14,
  parameter int ID_LEN    = 5,
  parameter int ROW_LEN   = 4,
  parameter int VALUE_LEN = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  gin_multicast_if.slave                            src,
  input  logic                                      i_set_id,
  input  logic [ID_LEN-1:0]                         i_id_scan_in,
  output logic [ID_LEN-1:0]                         o_id_scan_out,
  input  logic                                      i_set_row,
  input  logic [ROW_LEN-1:0]                        i_row_scan_in,
  output logic [ROW_LEN-1:0]                        o_row_scan_out,
  input  logic [PE_NUMS*XBUS_NUMS-1:0]              i_pe_ready,
  output logic [(VALUE_LEN+1)*PE_NUMS*XBUS_NUMS-1:0] o_pe_enable_data
);
  localparam int NPE = XBUS_NUMS * PE_NUMS;
  localparam int SLW = VALUE_LEN + 1;
  localparam logic [ROW_LEN-1:0] ROW_UNCFG = '1;

  logic [ROW_LEN-1:0]   r_row_id [XBUS_NUMS];
  logic [XBUS_NUMS-1:0] w_bus_hit;
  logic [ID_LEN-1:0]    w_id [NPE];
  logic [NPE-1:0]       w_blocked;

  // Row scan chain: a word enters bus 0 and moves one bus per shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < XBUS_NUMS; i++) r_row_id[i] <= ROW_UNCFG;
    end else if (i_set_row) begin
      r_row_id[0] <= i_row_scan_in;
      for (int i = 1; i < XBUS_NUMS; i++) r_row_id[i] <= r_row_id[i-1];
    end
  end

  assign o_row_scan_out = r_row_id[XBUS_NUMS-1];
  assign o_id_scan_out  = w_id[NPE-1];

  generate
    for (genvar i = 0; i < XBUS_NUMS; i++) begin : g_bus
      assign w_bus_hit[i] = (r_row_id[i] == src.row_tag) && (r_row_id[i] != ROW_UNCFG);

      for (genvar j = 0; j < PE_NUMS; j++) begin : g_pe
        localparam int K = i * PE_NUMS + j;
        logic [ID_LEN-1:0] w_chain_in;

        // The ID chain runs through PEs in flat index order across buses.
        if (K == 0) begin : g_head
          assign w_chain_in = i_id_scan_in;
        end else begin : g_link
          assign w_chain_in = w_id[K-1];
        end

        gin_multicast_pe #(
          .ID_LEN   (ID_LEN),
          .VALUE_LEN(VALUE_LEN)
        ) u_pe (
          .clk       (clk),
          .rst       (rst),
          .i_shift   (i_set_id),
          .i_id_in   (w_chain_in),
          .o_id      (w_id[K]),
          .i_bus_hit (w_bus_hit[i]),
          .i_col_tag (src.col_tag),
          .i_enable  (src.enable),
          .i_value   (src.value),
          .i_pe_ready(i_pe_ready[K]),
          .o_en_data (o_pe_enable_data[K*SLW +: SLW]),
          .o_blocked (w_blocked[K])
        );
      end
    end
  endgenerate

  // No hit PE means nothing blocks, so an untargeted transaction is consumed.
  // Reset kills ready at once, without waiting for the cleared IDs.
  assign src.ready = src.enable & ~rst & ~(|w_blocked);
endmodule

// File: tb/tb_gin_multicast.sv
module tb_gin_multicast;
  localparam int XB  = 12;
  localparam int PN  = 14;
  localparam int NPE = XB * PN;
  localparam int IL  = 5;
  localparam int RL  = 4;
  localparam int VL  = 8;
  localparam int SLW = VL + 1;
  localparam int W   = SLW * NPE;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           set_id = 1'b0, set_row = 1'b0;
  logic [IL-1:0]  id_in = '0, id_out;
  logic [RL-1:0]  row_in = '0, row_out;
  logic [NPE-1:0] pe_ready = '1;
  logic [W-1:0]   ped;

  int nvec = 0;
  int nerr = 0;

  // Reference model: a configuration is the history of words pushed into
  // each chain. Position p holds the p-th most recent word, or all-ones.
  logic [RL-1:0] row_hist[$];
  logic [IL-1:0] id_hist[$];
  logic [RL-1:0] cfg_row[XB];
  logic [IL-1:0] cfg_id[NPE];

  gin_multicast_if #(.ROW_LEN(RL), .ID_LEN(IL), .VALUE_LEN(VL)) bus();

  gin_multicast #(
    .XBUS_NUMS(XB), .PE_NUMS(PN), .ID_LEN(IL), .ROW_LEN(RL), .VALUE_LEN(VL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .src             (bus),
    .i_set_id        (set_id),
    .i_id_scan_in    (id_in),
    .o_id_scan_out   (id_out),
    .i_set_row       (set_row),
    .i_row_scan_in   (row_in),
    .o_row_scan_out  (row_out),
    .i_pe_ready      (pe_ready),
    .o_pe_enable_data(ped)
  );

  always #5 clk = ~clk;

  function automatic logic [RL-1:0] m_row(input int p);
    if (p < row_hist.size()) return row_hist[row_hist.size()-1-p];
    return '1;
  endfunction

  function automatic logic [IL-1:0] m_id(input int p);
    if (p < id_hist.size()) return id_hist[id_hist.size()-1-p];
    return '1;
  endfunction

  function automatic logic [NPE-1:0] m_hits(input logic [RL-1:0] rt, input logic [IL-1:0] ct);
    logic [NPE-1:0] h;
    h = '0;
    for (int k = 0; k < NPE; k++) begin
      logic [RL-1:0] r;
      logic [IL-1:0] d;
      r = m_row(k / PN);
      d = m_id(k);
      h[k] = (r == rt) && (r != '1) && (d == ct) && (d != '1);
    end
    return h;
  endfunction

  function automatic logic [W-1:0] m_vec(input logic en, input logic [NPE-1:0] h, input logic [VL-1:0] v);
    logic [W-1:0] o;
    for (int k = 0; k < NPE; k++) o[k*SLW +: SLW] = {en & h[k], v};
    return o;
  endfunction

  function automatic logic m_ready(input logic en, input logic [NPE-1:0] h, input logic [NPE-1:0] pr);
    return en && ((h & ~pr) == '0);
  endfunction

  function automatic logic [NPE-1:0] en_bits(input logic [W-1:0] v);
    logic [NPE-1:0] e;
    for (int k = 0; k < NPE; k++) e[k] = v[k*SLW + VL];
    return e;
  endfunction

  function automatic int first_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int k = 0; k < NPE; k++) if (a[k*SLW +: SLW] !== b[k*SLW +: SLW]) return k;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [RL-1:0] rt, input logic [IL-1:0] ct, input logic [VL-1:0] v);
    bus.enable  = en;
    bus.row_tag = rt;
    bus.col_tag = ct;
    bus.value   = v;
  endtask

  // Loads cfg_row/cfg_id with both chains shifting together for the first
  // XB cycles, checking the scan tails against the model along the way.
  task automatic load_config();
    for (int c = 0; c < NPE; c++) begin
      set_id = 1'b1;
      id_in  = cfg_id[NPE-1-c];
      set_row = (c < XB);
      row_in  = (c < XB) ? cfg_row[XB-1-c] : '0;
      tick();
      id_hist.push_back(cfg_id[NPE-1-c]);
      if (c < XB) row_hist.push_back(cfg_row[XB-1-c]);
      nvec++;
      if (id_out !== m_id(NPE-1) || row_out !== m_row(XB-1)) begin
        $display("FAIL load_scan c=%0d: id_out=%h row_out=%h want %h %h", c, id_out, row_out, m_id(NPE-1), m_row(XB-1));
        nerr++;
      end
    end
    set_id = 1'b0;
    set_row = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] ev;
    int fd;
    row_hist.delete();
    id_hist.delete();
    rst = 1'b1;
    pe_ready = '1;
    drive(1'b1, '0, '0, 8'h3C);
    #2;
    nvec++;
    if (bus.ready !== 1'b0) begin $display("FAIL reset_ready_held: got %b want 0", bus.ready); nerr++; end
    tick();
    rst = 1'b0;
    #2;
    ev = m_vec(1'b1, m_hits('0, '0), 8'h3C);
    nvec++;
    if (ped !== ev || en_bits(ped) !== '0) begin
      fd = first_diff(ped, ev);
      $display("FAIL reset_pe_out: pe %0d got %h want %h", fd, ped[fd*SLW +: SLW], ev[fd*SLW +: SLW]);
      nerr++;
    end
    nvec++;
    if (bus.ready !== 1'b1) begin $display("FAIL reset_ready: got %b want 1", bus.ready); nerr++; end
    nvec++;
    if (id_out !== 5'h1F || row_out !== 4'hF) begin
      $display("FAIL reset_scan_out: id=%h row=%h want 1f f", id_out, row_out);
      nerr++;
    end
    drive(1'b1, 4'hF, 5'h1F, 8'h11);
    #2;
    nvec++;
    if (en_bits(ped) !== '0 || bus.ready !== 1'b1) begin
      $display("FAIL reset_allones_tag: en=%0d ready=%b want 0 1", $countones(en_bits(ped)), bus.ready);
      nerr++;
    end
    tick();
  endtask

  task automatic test_row_chain();
    drive(1'b0, '0, '0, '0);
    for (int w = 0; w < XB; w++) begin
      set_row = 1'b1;
      row_in  = RL'(w);
      tick();
      row_hist.push_back(RL'(w));
      nvec++;
      if (row_out !== m_row(XB-1)) begin
        $display("FAIL row_shift %0d: got %h want %h", w, row_out, m_row(XB-1));
        nerr++;
      end
    end
    set_row = 1'b0;
    nvec++;
    if (row_out !== 4'h0) begin $display("FAIL row_tail_first: got %h want 0", row_out); nerr++; end
    tick();
    tick();
    nvec++;
    if (row_out !== 4'h0 || id_out !== 5'h1F) begin
      $display("FAIL row_hold: row=%h id=%h want 0 1f", row_out, id_out);
      nerr++;
    end
  endtask

  task automatic test_id_chain();
    logic [NPE-1:0] oh;
    logic [W-1:0] ev;
    int i, fd;
    for (int b = 0; b < XB; b++) cfg_row[b] = RL'(b);
    for (int k = 0; k < NPE; k++) cfg_id[k] = IL'(k % PN);
    load_config();
    pe_ready = '1;
    for (int n = 0; n < 5; n++) begin
      i = (n == 0) ? 0 : int'($urandom_range(0, XB-1));
      drive(1'b1, RL'(i), 5'd3, 8'hA5);
      #2;
      oh = '0;
      oh[i*PN+3] = 1'b1;
      ev = m_vec(1'b1, m_hits(RL'(i), 5'd3), 8'hA5);
      nvec++;
      if (ped !== ev || en_bits(ped) !== oh) begin
        fd = first_diff(ped, ev);
        $display("FAIL id_target bus %0d: pe %0d got %h want %h", i, fd, ped[fd*SLW +: SLW], ev[fd*SLW +: SLW]);
        nerr++;
      end
      nvec++;
      if (bus.ready !== 1'b1) begin $display("FAIL id_ready bus %0d: got %b want 1", i, bus.ready); nerr++; end
      tick();
    end
  endtask

  task automatic test_multicast();
    logic [W-1:0] ev;
    logic [VL-1:0] v;
    int fd;
    for (int b = 0; b < XB; b++) cfg_row[b] = (b == 2 || b == 7) ? 4'd0 : RL'(b + 1);
    for (int k = 0; k < NPE; k++) cfg_id[k] = IL'(6 + k % PN);
    cfg_id[2*PN+4] = 5'd5;
    cfg_id[2*PN+9] = 5'd5;
    cfg_id[7*PN+0] = 5'd5;
    drive(1'b0, '0, '0, '0);
    load_config();
    v = VL'($urandom);
    pe_ready = '1;
    pe_ready[7*PN] = 1'b0;
    drive(1'b1, 4'd0, 5'd5, v);
    #2;
    ev = m_vec(1'b1, m_hits(4'd0, 5'd5), v);
    nvec++;
    if (ped !== ev || $countones(en_bits(ped)) != 3) begin
      fd = first_diff(ped, ev);
      $display("FAIL mc_targets: pe %0d got %h want %h", fd, ped[fd*SLW +: SLW], ev[fd*SLW +: SLW]);
      nerr++;
    end
    nvec++;
    if (bus.ready !== 1'b0 || bus.ready !== m_ready(1'b1, m_hits(4'd0, 5'd5), pe_ready)) begin
      $display("FAIL mc_stall: got %b want 0", bus.ready);
      nerr++;
    end
    tick();
    pe_ready[7*PN] = 1'b1;
    pe_ready[5]    = 1'b0;   // not a hit PE, must not matter
    #2;
    nvec++;
    if (bus.ready !== 1'b1) begin $display("FAIL mc_release: got %b want 1", bus.ready); nerr++; end
    tick();
    pe_ready = '1;
  endtask

  task automatic test_unmatched();
    pe_ready = '0;
    drive(1'b1, 4'd15, 5'd31, 8'h5A);
    #2;
    nvec++;
    if (en_bits(ped) !== '0 || bus.ready !== 1'b1) begin
      $display("FAIL unmatched_en1: en=%0d ready=%b want 0 1", $countones(en_bits(ped)), bus.ready);
      nerr++;
    end
    drive(1'b0, 4'd15, 5'd31, 8'h5A);
    #2;
    nvec++;
    if (en_bits(ped) !== '0 || bus.ready !== 1'b0) begin
      $display("FAIL unmatched_en0: en=%0d ready=%b want 0 0", $countones(en_bits(ped)), bus.ready);
      nerr++;
    end
    tick();
    pe_ready = '1;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'd0, 5'd5, 8'h77);
    #2;
    nvec++;
    if ($countones(en_bits(ped)) != 3 || bus.ready !== 1'b1) begin
      $display("FAIL mid_pre: en=%0d ready=%b want 3 1", $countones(en_bits(ped)), bus.ready);
      nerr++;
    end
    rst = 1'b1;
    row_hist.delete();
    id_hist.delete();
    #2;
    nvec++;
    if (en_bits(ped) !== '0 || bus.ready !== 1'b0) begin
      $display("FAIL mid_rst: en=%0d ready=%b want 0 0", $countones(en_bits(ped)), bus.ready);
      nerr++;
    end
    tick();
    rst = 1'b0;
    #2;
    nvec++;
    if (en_bits(ped) !== '0 || bus.ready !== 1'b1 || id_out !== 5'h1F || row_out !== 4'hF) begin
      $display("FAIL mid_after: en=%0d ready=%b id=%h row=%h want 0 1 1f f", $countones(en_bits(ped)), bus.ready, id_out, row_out);
      nerr++;
    end
    tick();
  endtask

  // Random traffic with scan shifts landing in the same cycles as
  // transactions; the model only advances after the edge.
  task automatic test_back_to_back();
    logic [W-1:0] ev;
    logic [NPE-1:0] h;
    logic sr, si;
    logic [RL-1:0] rw;
    logic [IL-1:0] iw;
    int fd;
    for (int b = 0; b < XB; b++) cfg_row[b] = RL'($urandom_range(0, 3));
    for (int k = 0; k < NPE; k++) cfg_id[k] = IL'($urandom_range(0, 7));
    drive(1'b0, '0, '0, '0);
    load_config();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NPE; k++) pe_ready[k] = ($urandom_range(0, 31) != 0);
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0) ? 4'hF : RL'($urandom_range(0, 3)),
            IL'($urandom_range(0, 7)), VL'($urandom));
      sr = ($urandom_range(0, 3) == 0);
      si = ($urandom_range(0, 3) == 0);
      rw = RL'($urandom_range(0, 3));
      iw = IL'($urandom_range(0, 7));
      set_row = sr; row_in = rw;
      set_id  = si; id_in  = iw;
      #2;
      h  = m_hits(bus.row_tag, bus.col_tag);
      ev = m_vec(bus.enable, h, bus.value);
      nvec++;
      if (ped !== ev) begin
        fd = first_diff(ped, ev);
        $display("FAIL b2b_pe n=%0d: pe %0d got %h want %h", n, fd, ped[fd*SLW +: SLW], ev[fd*SLW +: SLW]);
        nerr++;
      end
      nvec++;
      if (bus.ready !== m_ready(bus.enable, h, pe_ready)) begin
        $display("FAIL b2b_ready n=%0d: got %b want %b", n, bus.ready, m_ready(bus.enable, h, pe_ready));
        nerr++;
      end
      tick();
      if (sr) row_hist.push_back(rw);
      if (si) id_hist.push_back(iw);
    end
    set_row = 1'b0;
    set_id  = 1'b0;
    pe_ready = '1;
  endtask

  task automatic test_sweep();
    logic [W-1:0] ev;
    int fd;
    for (int b = 0; b < XB; b++) cfg_row[b] = (b == 0) ? 4'hF : RL'($urandom_range(0, 8));
    for (int k = 0; k < NPE; k++) cfg_id[k] = IL'($urandom_range(0, 31));
    drive(1'b0, '0, '0, '0);
    load_config();
    pe_ready = '1;
    for (int t = 0; t < 60; t++) begin
      for (int r = 0; r < 224; r++) begin
        drive(1'b1, RL'(r / 30), IL'(r % 30), VL'($urandom));
        #2;
        ev = m_vec(1'b1, m_hits(bus.row_tag, bus.col_tag), bus.value);
        nvec++;
        if (ped !== ev) begin
          fd = first_diff(ped, ev);
          $display("FAIL sweep_pe t=%0d r=%0d: pe %0d got %h want %h", t, r, fd, ped[fd*SLW +: SLW], ev[fd*SLW +: SLW]);
          nerr++;
        end
        nvec++;
        if (bus.ready !== 1'b1) begin
          $display("FAIL sweep_ready t=%0d r=%0d: got %b want 1", t, r, bus.ready);
          nerr++;
        end
        tick();
      end
    end
    drive(1'b0, '0, '0, '0);
  endtask

  initial begin
    drive(1'b0, '0, '0, '0);
    #12;
    test_reset();
    test_row_chain();
    test_id_chain();
    test_multicast();
    test_unmatched();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
